// File: rtl/seg_spin_decoder.sv
// Receive-side lock/lap/error decoder for the 36-step 7-segment spin pattern.
// Optional err_count output is enabled by defining SEG_SPIN_DECODER_ERRCNT_EN.
module seg_spin_decoder #(
    parameter int LOCK_LEN = 4,
    parameter int LAP_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_in,
    input  logic [7:0]       seg_in,
    input  logic [3:0]       an_in,
    output logic             locked,
    output logic [5:0]       pos_idx,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_count,
    output logic             err_pulse
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    // state  | meaning
    // HUNT   | waiting for a sample equal to position 0
    // SYNC   | counting consecutive in-sequence samples toward LOCK_LEN
    // LOCK   | locked; tracking position, laps and deviations
    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    localparam logic [5:0] LOCK_LEN_C = 6'(LOCK_LEN);

    function automatic logic [7:0] step_seg(input logic [3:0] step);
        case (step)
            4'd0:    step_seg = 8'h7F;
            4'd1:    step_seg = 8'hBF;
            4'd2:    step_seg = 8'hFD;
            4'd3:    step_seg = 8'hF7;
            4'd4:    step_seg = 8'hEF;
            4'd5:    step_seg = 8'hDF;
            4'd6:    step_seg = 8'hFD;
            4'd7:    step_seg = 8'hFB;
            default: step_seg = 8'h7F;
        endcase
    endfunction

    function automatic logic [3:0] dig_an(input logic [1:0] dig);
        case (dig)
            2'd0:    dig_an = 4'b1110;
            2'd1:    dig_an = 4'b1101;
            2'd2:    dig_an = 4'b1011;
            default: dig_an = 4'b0111;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       step_q, step_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic [5:0]       pos_q, pos_d;
    logic             lap_pulse_q, lap_pulse_d;
    logic [LAP_W-1:0] lap_count_q, lap_count_d;
    logic             err_pulse_q, err_pulse_d;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
    logic [7:0]       err_count_q, err_count_d;
`endif

    logic [5:0] exp_pos;
    logic       is_match;
    logic       is_pos0;

    // Expected pointer is kept as digit/step; exp_pos = digit*9 + step.
    assign exp_pos  = {1'b0, dig_q, 3'b000} + {4'b0000, dig_q} + {2'b00, step_q};
    assign is_match = (seg_in == step_seg(step_q)) && (an_in == dig_an(dig_q));
    assign is_pos0  = (seg_in == 8'h7F) && (an_in == 4'b1110);

    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        pos_d       = pos_q;
        lap_pulse_d = 1'b0;
        lap_count_d = lap_count_q;
        err_pulse_d = 1'b0;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
        err_count_d = err_count_q;
`endif
        if (valid_in) begin
            if (state_q != S_HUNT && is_match) begin
                if (step_q == 4'd8) begin
                    step_d = 4'd0;
                    dig_d  = dig_q + 2'd1;
                end else begin
                    step_d = step_q + 4'd1;
                end
                if (state_q == S_LOCK) begin
                    pos_d = exp_pos;
                    if (exp_pos == 6'd0) begin
                        lap_pulse_d = 1'b1;
                        lap_count_d = lap_count_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == LOCK_LEN_C) begin
                        state_d  = S_LOCK;
                        locked_d = 1'b1;
                        pos_d    = exp_pos;
                    end
                end
            end else begin
                if (state_q == S_LOCK) begin
                    err_pulse_d = 1'b1;
                    locked_d    = 1'b0;
                    pos_d       = 6'd0;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
`endif
                end
                // A rejected sample may itself be a fresh position 0.
                if (is_pos0) begin
                    dig_d  = 2'd0;
                    step_d = 4'd1;
                    cnt_d  = 6'd1;
                    if (LOCK_LEN == 1) begin
                        state_d  = S_LOCK;
                        locked_d = 1'b1;
                        pos_d    = 6'd0;
                    end else begin
                        state_d = S_SYNC;
                    end
                end else begin
                    state_d = S_HUNT;
                    dig_d   = 2'd0;
                    step_d  = 4'd0;
                    cnt_d   = 6'd0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_HUNT;
            dig_q       <= 2'd0;
            step_q      <= 4'd0;
            cnt_q       <= 6'd0;
            locked_q    <= 1'b0;
            pos_q       <= 6'd0;
            lap_pulse_q <= 1'b0;
            lap_count_q <= '0;
            err_pulse_q <= 1'b0;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
            err_count_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            pos_q       <= pos_d;
            lap_pulse_q <= lap_pulse_d;
            lap_count_q <= lap_count_d;
            err_pulse_q <= err_pulse_d;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign pos_idx   = pos_q;
    assign lap_pulse = lap_pulse_q;
    assign lap_count = lap_count_q;
    assign err_pulse = err_pulse_q;
`ifdef SEG_SPIN_DECODER_ERRCNT_EN
    assign err_count = err_count_q;
`endif

endmodule
